// File: rtl/uart_tx_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_queue                                                            |
// | Byte FIFO feeding a UART transmitter through an IDLE/SEND/BUSY handshake |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_tx_queue #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic                     trmt,
  output logic [7:0]               tx_data,
  input  logic                     tx_done,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // SEND owns bit 0 alone so trmt is a plain flop output.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    BUSY = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      mem_q [DEPTH];
  logic            push;
  logic            pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign ovf     = ovf_q;
  assign trmt    = state_q[0];
  assign busy    = (state_q != IDLE);
  assign tx_data = tx_data_q;

  // Full is taken from the registered count, so a same-edge pop cannot free a slot.
  assign push = wr_en && !full;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = SEND;
          pop     = 1'b1;
        end
      end
      SEND: state_d = BUSY;
      BUSY: begin
        if (tx_done) begin
          if (!empty) begin
            state_d = SEND;
            pop     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    tx_data_d = tx_data_q;
    ovf_d     = wr_en && full;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      tx_data_d = mem_q[rd_ptr_q];
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tx_data_q <= 8'h00;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tx_data_q <= tx_data_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage needs no reset; the count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_tx_queue                                                         |
// | Directed self-checking bench for uart_tx_queue (DEPTH = 8)               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_uart_tx_queue;

  localparam int DEPTH = 8;
  localparam int FRAME = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       ovf;
  logic       trmt;
  logic [7:0] tx_data;
  logic       tx_done;
  logic       busy;

  uart_tx_queue #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .ovf     (ovf),
    .trmt    (trmt),
    .tx_data (tx_data),
    .tx_done (tx_done),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       tx_done;
    logic       exp_trmt;
    logic       exp_busy;
    logic [3:0] exp_count;
    logic       exp_empty;
    logic       exp_full;
    logic       exp_ovf;
    logic [7:0] exp_tx_data;
  } vec_t;

  vec_t       vecs [7];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         rise_cyc = -100;
  int         frame_left = 0;
  bit         model_en = 1'b0;
  logic [7:0] sent [$];
  int         pulse_cyc [$];
  int         pulse_rise [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: transmitter model reacts to the trmt seen in the cycle just ending.
  task automatic step();
    logic trmt_before;
    trmt_before = trmt;
    @(posedge clk);
    #1;
    cyc++;
    if (model_en) begin
      if (trmt_before) begin
        tx_done    = 1'b0;
        frame_left = FRAME;
      end else if (frame_left > 0) begin
        frame_left--;
        if (frame_left == 0) begin
          tx_done  = 1'b1;
          rise_cyc = cyc;
        end
      end
    end
    if (trmt) begin
      sent.push_back(tx_data);
      pulse_cyc.push_back(cyc);
      pulse_rise.push_back(rise_cyc);
    end
  endtask

  task automatic clear_log();
    sent.delete();
    pulse_cyc.delete();
    pulse_rise.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_trmt"},    trmt,    0);
    check({tag, "_busy"},    busy,    0);
    check({tag, "_count"},   count,   0);
    check({tag, "_empty"},   empty,   1);
    check({tag, "_full"},    full,    0);
    check({tag, "_ovf"},     ovf,     0);
    check({tag, "_tx_data"}, tx_data, 8'h00);
  endtask

  initial begin
    int i;
    int ovf_seen;
    int sz;

    // wr_en wr_data tx_done | trmt busy count empty full ovf tx_data
    vecs[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 8'hA5};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 8'hA5};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 8'hA5};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 8'hA5};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'hA5};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'hA5};

    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    tx_done = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Single byte through an idle queue, tx_done driven from the table.
    for (int v = 0; v < 7; v++) begin
      wr_en   = vecs[v].wr_en;
      wr_data = vecs[v].wr_data;
      tx_done = vecs[v].tx_done;
      step();
      check($sformatf("vec%0d_trmt", v),    trmt,    vecs[v].exp_trmt);
      check($sformatf("vec%0d_busy", v),    busy,    vecs[v].exp_busy);
      check($sformatf("vec%0d_count", v),   count,   vecs[v].exp_count);
      check($sformatf("vec%0d_empty", v),   empty,   vecs[v].exp_empty);
      check($sformatf("vec%0d_full", v),    full,    vecs[v].exp_full);
      check($sformatf("vec%0d_ovf", v),     ovf,     vecs[v].exp_ovf);
      check($sformatf("vec%0d_tx_data", v), tx_data, vecs[v].exp_tx_data);
    end

    // Three bytes with the transmitter model running.
    clear_log();
    wr_en    = 1'b0;
    model_en = 1'b1;
    for (int b = 1; b <= 3; b++) begin
      wr_en   = 1'b1;
      wr_data = 8'(b);
      step();
    end
    wr_en = 1'b0;
    i = 0;
    while (i < 200 && (busy || !empty)) begin
      step();
      i++;
    end
    check("three_drain_timeout", (i < 200), 1);
    sz = sent.size();
    check("three_count", sz, 3);
    for (int k = 0; k < 3; k++) begin
      if (k < sz) check($sformatf("three_byte%0d", k), sent[k], k + 1);
    end
    for (int k = 1; k < 3; k++) begin
      if (k < sz) check($sformatf("three_gap%0d", k), pulse_cyc[k] - pulse_rise[k], 1);
    end
    check("three_idle_empty", empty, 1);
    check("three_idle_busy", busy, 0);

    // Stalled transmitter: ten pushes into DEPTH 8.
    model_en = 1'b0;
    tx_done  = 1'b0;
    clear_log();
    for (int p = 0; p < 10; p++) begin
      wr_en   = 1'b1;
      wr_data = 8'h10 + 8'(p);
      step();
      check($sformatf("stall%0d_count", p), count, (p == 0) ? 1 : ((p > 8) ? 8 : p));
      check($sformatf("stall%0d_ovf", p), ovf, (p == 9) ? 1 : 0);
    end
    check("stall_full", full, 1);
    check("stall_inflight", tx_data, 8'h10);
    wr_en = 1'b0;
    step();
    check("stall_ovf_oneshot", ovf, 0);
    check("stall_count_hold", count, 8);

    // Full queue: push on the same edge as a BUSY->SEND pop is rejected.
    tx_done = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    step();
    wr_en = 1'b0;
    check("fullpop_ovf", ovf, 1);
    check("fullpop_count", count, 7);
    check("fullpop_trmt", trmt, 1);
    check("fullpop_tx_data", tx_data, 8'h11);
    check("fullpop_full", full, 0);
    model_en = 1'b1;
    i = 0;
    while (i < 300 && (busy || !empty)) begin
      step();
      i++;
    end
    check("stall_drain_timeout", (i < 300), 1);
    sz = sent.size();
    check("stall_sent_count", sz, 9);
    for (int k = 0; k < 9; k++) begin
      if (k < sz) check($sformatf("stall_byte%0d", k), sent[k], 8'h10 + k);
    end

    // Twenty bytes streamed so both pointers wrap.
    clear_log();
    i        = 0;
    ovf_seen = 0;
    for (int n = 0; n < 1000; n++) begin
      if (i < 20 && !full) begin
        wr_en   = 1'b1;
        wr_data = 8'h40 + 8'(i);
        i++;
      end else begin
        wr_en = 1'b0;
      end
      step();
      if (ovf) ovf_seen++;
      if (i == 20 && !busy && empty) break;
    end
    wr_en = 1'b0;
    check("stream_done", (i == 20 && !busy && empty), 1);
    check("stream_no_ovf", ovf_seen, 0);
    sz = sent.size();
    check("stream_sent_count", sz, 20);
    for (int k = 0; k < 20; k++) begin
      if (k < sz) check($sformatf("stream_byte%0d", k), sent[k], 8'h40 + k);
    end

    // Asynchronous reset while BUSY with four bytes queued.
    model_en = 1'b0;
    tx_done  = 1'b0;
    for (int p = 0; p < 5; p++) begin
      wr_en   = 1'b1;
      wr_data = 8'h80 + 8'(p);
      step();
    end
    wr_en = 1'b0;
    check("prerst_count", count, 4);
    check("prerst_busy", busy, 1);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    #2;
    rst     = 1'b0;
    tx_done = 1'b1;
    clear_log();
    for (int p = 0; p < 4; p++) step();
    check("postrst_no_trmt", sent.size(), 0);
    check("postrst_busy", busy, 0);
    wr_en   = 1'b1;
    wr_data = 8'h77;
    step();
    wr_en = 1'b0;
    check("firstpush_count", count, 1);
    step();
    check("firstpush_trmt", trmt, 1);
    check("firstpush_tx_data", tx_data, 8'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
